// File: rtl/sv32_page_walker_pkg.sv
// Shared Sv32 PTE layout, fault cause codes and walker state encoding.
// Imported by the page walker top and its PTE checker.
package sv32_page_walker_pkg;

  localparam int PTE_V       = 0;
  localparam int PTE_R       = 1;
  localparam int PTE_W       = 2;
  localparam int PTE_X       = 3;
  localparam int PTE_U       = 4;
  localparam int PTE_G       = 5;
  localparam int PTE_A       = 6;
  localparam int PTE_D       = 7;
  localparam int PTE_PPN_LSB = 10;

  localparam int PAGE_SHIFT = 12;
  localparam int PTE_BYTES  = 4;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_INVALID  = 2'd1;
  localparam logic [1:0] CAUSE_PERM     = 2'd2;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_L1_REQ,
    S_L1_WAIT,
    S_L0_REQ,
    S_L0_WAIT,
    S_AD_WR,
    S_RESP
  } walk_state_t;

endpackage

// File: rtl/sv32_page_walker_pte_checker.sv
// Combinational Sv32 PTE decode: leaf/pointer, fault cause and A/D-updated PTE.
// Zero latency; no flow control.
module sv32_page_walker_pte_checker
  import sv32_page_walker_pkg::*;
#(
  parameter int PTE_WIDTH = 32
) (
  input  logic [PTE_WIDTH-1:0] pte,
  input  logic                 level1,
  input  logic                 is_write,
  input  logic                 is_exec,
  input  logic                 is_user,
  output logic                 is_leaf,
  output logic                 fault,
  output logic [1:0]           cause,
  output logic                 need_ad,
  output logic [PTE_WIDTH-1:0] pte_upd
);

  logic perm_bad;

  always_comb begin
    is_leaf  = pte[PTE_R] | pte[PTE_W] | pte[PTE_X];
    fault    = 1'b0;
    cause    = CAUSE_NONE;
    // A load is any access that is neither a store nor a fetch.
    perm_bad = (is_write && !pte[PTE_W]) ||
               (is_exec && !pte[PTE_X]) ||
               (!is_write && !is_exec && !pte[PTE_R]) ||
               (is_user != pte[PTE_U]);

    if (!pte[PTE_V] || (!pte[PTE_R] && pte[PTE_W])) begin
      fault = 1'b1;
      cause = CAUSE_INVALID;
    end else if (!is_leaf) begin
      if (!level1) begin
        fault = 1'b1;
        cause = CAUSE_INVALID;
      end
    end else if (level1 && (pte[PTE_PPN_LSB+9:PTE_PPN_LSB] != 10'd0)) begin
      fault = 1'b1;
      cause = CAUSE_MISALIGN;
    end else if (perm_bad) begin
      fault = 1'b1;
      cause = CAUSE_PERM;
    end

    pte_upd          = pte;
    pte_upd[PTE_A]   = 1'b1;
    if (is_write) begin
      pte_upd[PTE_D] = 1'b1;
    end
    need_ad = !fault && is_leaf && (!pte[PTE_A] || (is_write && !pte[PTE_D]));
  end

endmodule

// File: rtl/sv32_page_walker.sv
// Two-level Sv32 page-table walker with A/D write-back; one memory transaction outstanding.
// Requests accepted only in IDLE; memory requests and results held until their ready handshake.
module sv32_page_walker
  import sv32_page_walker_pkg::*;
#(
  parameter int PPN_WIDTH = 22,
  parameter int PA_WIDTH  = 34,
  parameter int PTE_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [31:0]          req_vaddr,
  input  logic                 req_is_write,
  input  logic                 req_is_exec,
  input  logic                 req_is_user,
  input  logic [PPN_WIDTH-1:0] satp_ppn,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [PA_WIDTH-1:0]  mem_req_addr,
  output logic                 mem_req_we,
  output logic [PTE_WIDTH-1:0] mem_req_wdata,
  input  logic                 mem_resp_valid,
  input  logic [PTE_WIDTH-1:0] mem_resp_data,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [PPN_WIDTH-1:0] resp_ppn,
  output logic                 resp_superpage,
  output logic                 resp_fault,
  output logic [1:0]           resp_cause,
  output logic [PTE_WIDTH-1:0] resp_pte
);

  walk_state_t          state, state_nxt;
  logic [9:0]           vpn1_q, vpn0_q;
  logic                 wr_q, ex_q, us_q;
  logic [PA_WIDTH-1:0]  addr_q;
  logic [PTE_WIDTH-1:0] pte_q;
  logic [PPN_WIDTH-1:0] ppn_q;
  logic                 super_q, fault_q;
  logic [1:0]           cause_q;

  logic                 in_wait, level1, resp_take;
  logic                 is_leaf, chk_fault, need_ad;
  logic [1:0]           chk_cause;
  logic [PTE_WIDTH-1:0] pte_upd;
  logic                 unused_vaddr_lsbs;

  assign unused_vaddr_lsbs = ^req_vaddr[11:0];

  assign level1    = (state == S_L1_WAIT);
  assign in_wait   = (state == S_L1_WAIT) || (state == S_L0_WAIT);
  assign resp_take = in_wait && mem_resp_valid;

  sv32_page_walker_pte_checker #(.PTE_WIDTH(PTE_WIDTH)) u_pte_checker (
    .pte      (mem_resp_data),
    .level1   (level1),
    .is_write (wr_q),
    .is_exec  (ex_q),
    .is_user  (us_q),
    .is_leaf  (is_leaf),
    .fault    (chk_fault),
    .cause    (chk_cause),
    .need_ad  (need_ad),
    .pte_upd  (pte_upd)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (req_valid) state_nxt = S_L1_REQ;
      S_L1_REQ:  if (mem_req_ready) state_nxt = S_L1_WAIT;
      S_L0_REQ:  if (mem_req_ready) state_nxt = S_L0_WAIT;
      S_L1_WAIT,
      S_L0_WAIT: begin
        if (mem_resp_valid) begin
          if (!chk_fault && !is_leaf) state_nxt = S_L0_REQ;
          else if (need_ad)           state_nxt = S_AD_WR;
          else                        state_nxt = S_RESP;
        end
      end
      S_AD_WR:   if (mem_req_ready) state_nxt = S_RESP;
      S_RESP:    if (resp_ready) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // addr_q keeps the leaf read address so the A/D write-back reuses it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpn1_q  <= '0;
      vpn0_q  <= '0;
      wr_q    <= 1'b0;
      ex_q    <= 1'b0;
      us_q    <= 1'b0;
      addr_q  <= '0;
      pte_q   <= '0;
      ppn_q   <= '0;
      super_q <= 1'b0;
      fault_q <= 1'b0;
      cause_q <= CAUSE_NONE;
    end else if (state == S_IDLE && req_valid) begin
      vpn1_q <= req_vaddr[31:22];
      vpn0_q <= req_vaddr[21:12];
      wr_q   <= req_is_write;
      ex_q   <= req_is_exec;
      us_q   <= req_is_user;
      addr_q <= PA_WIDTH'({satp_ppn, {PAGE_SHIFT{1'b0}}}) +
                PA_WIDTH'(req_vaddr[31:22]) * PA_WIDTH'(PTE_BYTES);
    end else if (resp_take) begin
      if (!chk_fault && !is_leaf) begin
        addr_q <= PA_WIDTH'({mem_resp_data[PTE_WIDTH-1:PTE_PPN_LSB], {PAGE_SHIFT{1'b0}}}) +
                  PA_WIDTH'(vpn0_q) * PA_WIDTH'(PTE_BYTES);
      end else begin
        fault_q <= chk_fault;
        cause_q <= chk_cause;
        super_q <= !chk_fault && level1;
        pte_q   <= chk_fault ? mem_resp_data : pte_upd;
        if (chk_fault)   ppn_q <= '0;
        else if (level1) ppn_q <= {mem_resp_data[PTE_WIDTH-1:PTE_PPN_LSB+10], vpn0_q};
        else             ppn_q <= mem_resp_data[PTE_WIDTH-1:PTE_PPN_LSB];
      end
    end
  end

  assign req_ready      = (state == S_IDLE);
  assign mem_req_valid  = (state == S_L1_REQ) || (state == S_L0_REQ) || (state == S_AD_WR);
  assign mem_req_we     = (state == S_AD_WR);
  assign mem_req_addr   = mem_req_valid ? addr_q : '0;
  assign mem_req_wdata  = mem_req_we ? pte_q : '0;
  assign resp_valid     = (state == S_RESP);
  assign resp_ppn       = resp_valid ? ppn_q : '0;
  assign resp_superpage = resp_valid && super_q;
  assign resp_fault     = resp_valid && fault_q;
  assign resp_cause     = resp_valid ? cause_q : CAUSE_NONE;
  assign resp_pte       = resp_valid ? pte_q : '0;

endmodule
